dg_pc_sequencer: RTL and testbench

//   Parametrised program-counter sequencer for the DG00xx 4-bit core family.

---
 rtl/dg_pc_pkg.sv | 35 +++
 rtl/dg_ret_stack.sv | 37 +++
 rtl/dg_pc_sequencer.sv | 145 ++++++++++++++
 tb/tb_dg_pc_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dg_pc_pkg.sv
// dg_pc_pkg: shared definitions for the DG00xx program-counter sequencer.
//   - op encodings (OP_NONE..OP_LDPAGE), codes 5-7 behave as OP_NONE
//   - default widths / depth / feedback tap
//   - lfsr_next(): one step of the XNOR offset LFSR, width- and tap-generic
package dg_pc_pkg;

  localparam logic [2:0] OP_NONE   = 3'd0;
  localparam logic [2:0] OP_JMP    = 3'd1;
  localparam logic [2:0] OP_CALL   = 3'd2;
  localparam logic [2:0] OP_RET    = 3'd3;
  localparam logic [2:0] OP_LDPAGE = 3'd4;

  localparam int unsigned PL_W_DEF   = 6;
  localparam int unsigned PU_W_DEF   = 4;
  localparam int unsigned FB_TAP_DEF = 1;
  localparam int unsigned DEPTH_DEF  = 5;

  // Widest offset the helper supports; callers zero-extend into this.
  localparam int unsigned LFSR_MAX_W = 32;

  // Shift right, feed ~(pl[0]^pl[tap]) into bit w-1. Bits at or above w in
  // the argument must be zero. All-ones is a fixed point (lock state).
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] pl,
    input int unsigned           w,
    input int unsigned           tap
  );
    logic tap_bit;
    logic fb;
    tap_bit = |(pl & (LFSR_MAX_W'(1) << tap));
    fb      = ~(pl[0] ^ tap_bit);
    return (pl >> 1) | (LFSR_MAX_W'(fb) << (w - 1));
  endfunction

endpackage

// File: rtl/dg_ret_stack.sv
// dg_ret_stack: DEPTH x W shift-register return stack, entry 0 is the top.
//   clk, rst_n : clock, async active-low reset (clears every entry)
//   push       : shift down, data_in into entry 0, oldest entry dropped
//   pop        : shift up, bottom entry keeps its value (duplicates)
//   data_in    : value pushed
//   top        : entry 0
// No occupancy tracking here; the parent owns any counter/flags.
module dg_ret_stack
  import dg_pc_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned W     = PU_W_DEF + PL_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] top
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[0] <= data_in;
      for (int unsigned i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end else if (pop) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
    end
  end

  assign top = mem[0];

endmodule

// File: rtl/dg_pc_sequencer.sv
// dg_pc_sequencer: program-counter sequencer for the DG00xx 4-bit core family.
// pc = {page (PU), LFSR offset (PL)}; state only moves when adv=1.
//   clk, rst_n : clock (rising), async active-low reset
//   adv        : step strobe; op/tgt/page_in sampled only when high
//   op         : NONE/JMP/CALL/RET/LDPAGE (5-7 act as NONE)
//   tgt        : jump/call offset
//   page_in    : page for LDPAGE prefix
//   clr_flags  : clears ovf/unf (a same-cycle set wins)
//   pc         : current ROM address
//   depth      : valid return-stack entries
//   ovf, unf   : sticky push-when-full / pop-when-empty
// Macro PCSEQ_STACK_FLAGS_EN builds the depth counter and ovf/unf flags;
// without it those outputs are tied 0 and the stack data path is unchanged.
module dg_pc_sequencer
  import dg_pc_pkg::*;
#(
  parameter int unsigned     PL_W      = PL_W_DEF,
  parameter int unsigned     PU_W      = PU_W_DEF,
  parameter int unsigned     FB_TAP    = FB_TAP_DEF,
  parameter int unsigned     DEPTH     = DEPTH_DEF,
  parameter logic [PU_W-1:0] CALL_PAGE = '1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       adv,
  input  logic [2:0]                 op,
  input  logic [PL_W-1:0]            tgt,
  input  logic [PU_W-1:0]            page_in,
  input  logic                       clr_flags,
  output logic [PU_W+PL_W-1:0]       pc,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       ovf,
  output logic                       unf
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = PU_W + PL_W;

  logic [PL_W-1:0] pl, pl_nxt, pl_step;
  logic [PU_W-1:0] pu, pu_nxt;
  logic            pend, pend_nxt;
  logic [PU_W-1:0] ppage, ppage_nxt;
  logic            push, pop;
  logic [AW-1:0]   stack_top;

  always_comb begin
    pl_nxt    = pl;
    pu_nxt    = pu;
    pend_nxt  = pend;
    ppage_nxt = ppage;
    push      = 1'b0;
    pop       = 1'b0;
    pl_step   = PL_W'(lfsr_next(LFSR_MAX_W'(pl), PL_W, FB_TAP));
    if (adv) begin
      // Page prefix lives for exactly one following op.
      pend_nxt = 1'b0;
      case (op)
        OP_JMP: begin
          pl_nxt = tgt;
          if (pend) pu_nxt = ppage;
        end
        OP_CALL: begin
          push   = 1'b1;
          pl_nxt = tgt;
          pu_nxt = pend ? ppage : CALL_PAGE;
        end
        OP_RET: begin
          pop              = 1'b1;
          {pu_nxt, pl_nxt} = stack_top;
        end
        OP_LDPAGE: begin
          pl_nxt   = pl_step;
          pend_nxt = 1'b1;
          if (!pend) ppage_nxt = page_in;
        end
        default: pl_nxt = pl_step;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pl    <= '0;
      pu    <= '0;
      pend  <= 1'b0;
      ppage <= '0;
    end else begin
      pl    <= pl_nxt;
      pu    <= pu_nxt;
      pend  <= pend_nxt;
      ppage <= ppage_nxt;
    end
  end

  assign pc = {pu, pl};

  dg_ret_stack #(
    .DEPTH (DEPTH),
    .W     (AW)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .data_in (pc),
    .top     (stack_top)
  );

`ifdef PCSEQ_STACK_FLAGS_EN
  logic [DW-1:0] depth_q;
  logic          ovf_q, unf_q;
  logic          full, empty;

  assign full  = (depth_q == DW'(DEPTH));
  assign empty = (depth_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (push && !full)      depth_q <= depth_q + DW'(1);
      else if (pop && !empty) depth_q <= depth_q - DW'(1);

      if (push && full)   ovf_q <= 1'b1;
      else if (clr_flags) ovf_q <= 1'b0;

      if (pop && empty)   unf_q <= 1'b1;
      else if (clr_flags) unf_q <= 1'b0;
    end
  end

  assign depth = depth_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
`else
  logic unused_clr;
  assign unused_clr = clr_flags;
  assign depth      = '0;
  assign ovf        = 1'b0;
  assign unf        = 1'b0;
`endif

endmodule

// File: tb/tb_dg_pc_sequencer.sv
module tb_dg_pc_sequencer;

  localparam int PL_W   = 6;
  localparam int PU_W   = 4;
  localparam int FB_TAP = 1;
  localparam int DEPTH  = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             adv = 1'b0;
  logic [2:0]       op = '0;
  logic [PL_W-1:0]  tgt = '0;
  logic [PU_W-1:0]  page_in = '0;
  logic             clr_flags = 1'b0;
  logic [9:0]       pc;
  logic [2:0]       depth;
  logic             ovf, unf;

  int checks = 0;
  int errors = 0;

  dg_pc_sequencer #(
    .PL_W   (PL_W),
    .PU_W   (PU_W),
    .FB_TAP (FB_TAP),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .adv       (adv),
    .op        (op),
    .tgt       (tgt),
    .page_in   (page_in),
    .clr_flags (clr_flags),
    .pc        (pc),
    .depth     (depth),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk = ~clk;

  // Reference model: page/offset as integers, stack as a plain array.
  int m_pu, m_pl, m_pend, m_ppage;
  int m_stk [DEPTH];
  int m_depth, m_ovf, m_unf;

  function automatic int m_pc();
    return m_pu * 64 + m_pl;
  endfunction

  function automatic int e_depth();
`ifdef PCSEQ_STACK_FLAGS_EN
    return m_depth;
`else
    return 0;
`endif
  endfunction

  function automatic int e_ovf();
`ifdef PCSEQ_STACK_FLAGS_EN
    return m_ovf;
`else
    return 0;
`endif
  endfunction

  function automatic int e_unf();
`ifdef PCSEQ_STACK_FLAGS_EN
    return m_unf;
`else
    return 0;
`endif
  endfunction

  function automatic void model_reset();
    m_pu = 0; m_pl = 0; m_pend = 0; m_ppage = 0;
    m_depth = 0; m_ovf = 0; m_unf = 0;
    for (int i = 0; i < DEPTH; i++) m_stk[i] = 0;
  endfunction

  function automatic void model_lfsr();
    int b0, bt, fb;
    b0 = m_pl % 2;
    bt = (m_pl / (1 << FB_TAP)) % 2;
    fb = (b0 == bt) ? 1 : 0;
    m_pl = m_pl / 2 + fb * 32;
  endfunction

  function automatic void model_step(int a, int o, int t, int p, int c);
    int cur, topv;
    if (c != 0) begin m_ovf = 0; m_unf = 0; end
    if (a == 0) return;
    cur = m_pc();
    case (o)
      1: begin
        m_pl = t;
        if (m_pend != 0) m_pu = m_ppage;
        m_pend = 0;
      end
      2: begin
        for (int i = DEPTH - 1; i > 0; i--) m_stk[i] = m_stk[i-1];
        m_stk[0] = cur;
        if (m_depth == DEPTH) m_ovf = 1; else m_depth++;
        m_pl = t;
        m_pu = (m_pend != 0) ? m_ppage : 15;
        m_pend = 0;
      end
      3: begin
        topv = m_stk[0];
        for (int i = 0; i < DEPTH - 1; i++) m_stk[i] = m_stk[i+1];
        if (m_depth == 0) m_unf = 1; else m_depth--;
        m_pu = topv / 64;
        m_pl = topv % 64;
        m_pend = 0;
      end
      4: begin
        if (m_pend == 0) begin m_pend = 1; m_ppage = p; end
        model_lfsr();
      end
      default: begin
        model_lfsr();
        m_pend = 0;
      end
    endcase
  endfunction

  task automatic do_op(input int a, input int o, input int t, input int p, input int c);
    @(negedge clk);
    adv = a[0]; op = o[2:0]; tgt = t[5:0]; page_in = p[3:0]; clr_flags = c[0];
    @(posedge clk);
    #1;
    model_step(a, o, t, p, c);
    adv = 1'b0; clr_flags = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (pc !== 10'h000) begin errors++; $display("FAIL reset_pc got %h want 000", pc); end
    checks++; if (depth !== 3'd0) begin errors++; $display("FAIL reset_depth got %0d want 0", depth); end
    checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", ovf, unf); end
  endtask

  task automatic test_lfsr();
    bit seen [1024];
    int want [3] = '{10'h020, 10'h030, 10'h038};
    int repeats = 0;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      do_op(1, 0, 0, 0, 0);
      checks++; if (pc !== want[i][9:0]) begin errors++; $display("FAIL lfsr_step%0d got %h want %h", i, pc, want[i]); end
    end
    apply_reset();
    for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
    seen[0] = 1'b1;
    for (int i = 0; i < 63; i++) begin
      do_op(1, 0, 0, 0, 0);
      checks++; if (pc !== m_pc()) begin errors++; $display("FAIL lfsr_model got %h want %h", pc, m_pc()); end
      if (i < 62 && seen[pc]) repeats++;
      seen[pc] = 1'b1;
    end
    checks++; if (pc !== 10'h000) begin errors++; $display("FAIL lfsr_period got %h want 000", pc); end
    checks++; if (repeats !== 0) begin errors++; $display("FAIL lfsr_norepeat got %0d want 0", repeats); end
    do_op(1, 1, 63, 0, 0);
    do_op(1, 0, 0, 0, 0);
    checks++; if (pc !== 10'h03F) begin errors++; $display("FAIL lfsr_lock got %h want 03f", pc); end
  endtask

  task automatic test_call_ret();
    apply_reset();
    do_op(1, 1, 5, 0, 0);
    checks++; if (pc !== 10'h005) begin errors++; $display("FAIL jmp5 got %h want 005", pc); end
    do_op(1, 2, 6'h12, 0, 0);
    checks++; if (pc !== 10'h3D2) begin errors++; $display("FAIL call_pc got %h want 3d2", pc); end
    checks++; if (depth !== e_depth()) begin errors++; $display("FAIL call_depth got %0d want %0d", depth, e_depth()); end
    do_op(1, 3, 0, 0, 0);
    checks++; if (pc !== 10'h005) begin errors++; $display("FAIL ret_pc got %h want 005", pc); end
    checks++; if (depth !== 3'd0) begin errors++; $display("FAIL ret_depth got %0d want 0", depth); end
  endtask

  task automatic test_prefix();
    apply_reset();
    do_op(1, 4, 0, 3, 0);
    do_op(1, 1, 6'h0A, 0, 0);
    checks++; if (pc !== 10'h0CA) begin errors++; $display("FAIL prefix_jmp got %h want 0ca", pc); end
    apply_reset();
    do_op(1, 4, 0, 3, 0);
    do_op(1, 4, 0, 7, 0);
    do_op(1, 1, 1, 0, 0);
    checks++; if (pc !== 10'h0C1) begin errors++; $display("FAIL prefix_first got %h want 0c1", pc); end
    apply_reset();
    do_op(1, 4, 0, 3, 0);
    do_op(1, 0, 0, 0, 0);
    do_op(1, 1, 1, 0, 0);
    checks++; if (pc !== 10'h001) begin errors++; $display("FAIL prefix_expire got %h want 001", pc); end
    do_op(1, 4, 0, 9, 0);
    do_op(1, 2, 7, 0, 0);
    checks++; if (pc !== 10'h247) begin errors++; $display("FAIL prefix_call got %h want 247", pc); end
  endtask

  task automatic test_stack();
    int pushed [6];
    int t;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      pushed[i] = m_pc();
      t = $urandom_range(0, 63);
      do_op(1, 2, t, 0, 0);
      checks++; if (pc !== m_pc()) begin errors++; $display("FAIL stack_call%0d got %h want %h", i, pc, m_pc()); end
    end
    checks++; if (ovf !== e_ovf()) begin errors++; $display("FAIL stack_ovf got %b want %0d", ovf, e_ovf()); end
    checks++; if (depth !== e_depth()) begin errors++; $display("FAIL stack_full_depth got %0d want %0d", depth, e_depth()); end
    for (int i = 5; i >= 1; i--) begin
      do_op(1, 3, 0, 0, 0);
      checks++; if (pc !== pushed[i][9:0]) begin errors++; $display("FAIL stack_ret%0d got %h want %h", i, pc, pushed[i]); end
    end
    checks++; if (unf !== 1'b0) begin errors++; $display("FAIL stack_unf_early got %b want 0", unf); end
    do_op(1, 3, 0, 0, 0);
    checks++; if (pc !== pushed[1][9:0]) begin errors++; $display("FAIL stack_ret_empty got %h want %h", pc, pushed[1]); end
    checks++; if (unf !== e_unf()) begin errors++; $display("FAIL stack_unf got %b want %0d", unf, e_unf()); end
    checks++; if (depth !== 3'd0) begin errors++; $display("FAIL stack_empty_depth got %0d want 0", depth); end
    do_op(0, 0, 0, 0, 1);
    checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL stack_clr got %b%b want 00", ovf, unf); end
    for (int i = 0; i < 5; i++) do_op(1, 2, i, 0, 0);
    do_op(1, 2, 9, 0, 1);
    checks++; if (ovf !== e_ovf()) begin errors++; $display("FAIL stack_set_wins got %b want %0d", ovf, e_ovf()); end
  endtask

  task automatic test_adv_low();
    logic [9:0] held;
    apply_reset();
    do_op(1, 2, 6'h2B, 0, 0);
    held = pc;
    for (int i = 0; i < 8; i++) begin
      do_op(0, $urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(0, 15), 0);
      checks++; if (pc !== held || depth !== e_depth()) begin errors++; $display("FAIL adv_low got %h/%0d want %h/%0d", pc, depth, held, e_depth()); end
    end
  endtask

  task automatic test_random();
    int a, o, c;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 4) != 0) ? 1 : 0;
      o = $urandom_range(0, 7);
      c = ($urandom_range(0, 7) == 0) ? 1 : 0;
      do_op(a, o, $urandom_range(0, 63), $urandom_range(0, 15), c);
      checks++;
      if (pc !== m_pc() || depth !== e_depth() || ovf !== e_ovf() || unf !== e_unf()) begin
        errors++;
        $display("FAIL random%0d got %h/%0d/%b%b want %h/%0d/%0d%0d", i, pc, depth, ovf, unf,
                 m_pc(), e_depth(), e_ovf(), e_unf());
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 3; i++) do_op(1, 2, i + 4, 0, 0);
    checks++; if (depth !== e_depth()) begin errors++; $display("FAIL mid_depth_pre got %0d want %0d", depth, e_depth()); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pc !== 10'h000) begin errors++; $display("FAIL mid_reset_pc got %h want 000", pc); end
    checks++; if (depth !== 3'd0 || ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL mid_reset_state got %0d/%b%b want 0/00", depth, ovf, unf); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1, 3, 0, 0, 0);
    checks++; if (pc !== 10'h000) begin errors++; $display("FAIL mid_reset_stack got %h want 000", pc); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lfsr();
    test_call_ret();
    test_prefix();
    test_stack();
    test_adv_low();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
